// File: rtl/aes_cbc_stream_source.sv
// Serialises an AES-256 CBC message (key, IV, then payload blocks) onto an
// AXI-Stream master feeding the cipher core, one M_AXIS_WIDTH beat at a time.
module aes_cbc_stream_source #(
  parameter int M_AXIS_WIDTH = 64
) (
  input  logic                      Clk,
  input  logic                      Rst_n,
  input  logic                      Cmd_valid,
  output logic                      Cmd_ready,
  input  logic [255:0]              Cmd_key,
  input  logic [127:0]              Cmd_iv,
  input  logic                      Cmd_encrypt,
  input  logic                      S_blk_tvalid,
  output logic                      S_blk_tready,
  input  logic [127:0]              S_blk_tdata,
  input  logic                      S_blk_tlast,
  output logic                      M_axis_tvalid,
  input  logic                      M_axis_tready,
  output logic [M_AXIS_WIDTH-1:0]   M_axis_tdata,
  output logic [M_AXIS_WIDTH/8-1:0] M_axis_tkeep,
  output logic                      M_axis_tlast,
  output logic                      M_axis_tuser,
  output logic                      Busy,
  output logic [15:0]               Block_cnt,
  output logic [3:0]                fsm_state
);

  localparam int W         = M_AXIS_WIDTH;
  localparam int KEY_WORDS = 256 / W;
  localparam int BLK_WORDS = 128 / W;

  typedef enum logic [3:0] {
    ST_IDLE = 4'b0001,
    ST_KEY  = 4'b0010,
    ST_IV   = 4'b0100,
    ST_TEXT = 4'b1000
  } state_t;

  state_t         state, state_next;
  logic [2:0]     cnt;
  logic [255:0]   key_reg;
  logic [127:0]   iv_reg;
  logic [127:0]   blk_reg;
  logic           enc_reg;
  logic           blk_valid;
  logic           blk_last;

  logic           hs;
  logic           key_end;
  logic           word128_end;
  logic           text_done;
  logic           cmd_acc;
  logic           blk_acc;
  logic [7:0]     key_ofs;
  logic [6:0]     w128_ofs;

  // Every stream here uses valid/ready: a transfer happens on a rising edge
  // where both are high; a source never withdraws valid or changes its payload
  // while waiting for ready.
  assign key_ofs     = 8'(cnt) * 8'(W);
  assign w128_ofs    = 7'(cnt) * 7'(W);
  assign key_end     = (cnt == 3'(KEY_WORDS - 1));
  assign word128_end = (cnt == 3'(BLK_WORDS - 1));

  assign Busy         = (state != ST_IDLE);
  assign fsm_state    = state;
  assign Cmd_ready    = (state == ST_IDLE) & Rst_n;
  assign cmd_acc      = Cmd_valid & Cmd_ready;
  assign hs           = M_axis_tvalid & M_axis_tready;
  assign text_done    = (state == ST_TEXT) & hs & word128_end;
  // A buffered final block blocks all further input until the message ends.
  assign S_blk_tready = Busy & ~(blk_valid & blk_last) & (~blk_valid | text_done);
  assign blk_acc      = S_blk_tvalid & S_blk_tready;

  always_comb begin
    M_axis_tvalid = 1'b0;
    M_axis_tdata  = '0;
    M_axis_tlast  = 1'b0;
    unique case (state)
      ST_KEY: begin
        M_axis_tvalid = 1'b1;
        M_axis_tdata  = key_reg[key_ofs +: W];
      end
      ST_IV: begin
        M_axis_tvalid = 1'b1;
        M_axis_tdata  = iv_reg[w128_ofs +: W];
      end
      ST_TEXT: begin
        M_axis_tvalid = blk_valid;
        M_axis_tdata  = blk_reg[w128_ofs +: W];
        M_axis_tlast  = blk_valid & blk_last & word128_end;
      end
      default: ;
    endcase
  end

  assign M_axis_tkeep = Busy ? '1 : '0;
  assign M_axis_tuser = Busy & enc_reg;

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: if (cmd_acc)                state_next = ST_KEY;
      ST_KEY:  if (hs && key_end)          state_next = ST_IV;
      ST_IV:   if (hs && word128_end)      state_next = ST_TEXT;
      ST_TEXT: if (text_done && blk_last)  state_next = ST_IDLE;
      default:                             state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cnt       <= '0;
      key_reg   <= '0;
      iv_reg    <= '0;
      enc_reg   <= 1'b0;
      Block_cnt <= '0;
    end else if (cmd_acc) begin
      cnt       <= '0;
      key_reg   <= Cmd_key;
      iv_reg    <= Cmd_iv;
      enc_reg   <= Cmd_encrypt;
      Block_cnt <= '0;
    end else if (hs) begin
      if ((state == ST_KEY && key_end) || (state != ST_KEY && word128_end))
        cnt <= '0;
      else
        cnt <= cnt + 3'd1;
      if (text_done)
        Block_cnt <= Block_cnt + 16'd1;
    end
  end

  // New block replaces the draining one on the same edge, so TEXT never bubbles.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      blk_reg   <= '0;
      blk_valid <= 1'b0;
      blk_last  <= 1'b0;
    end else if (blk_acc) begin
      blk_reg   <= S_blk_tdata;
      blk_valid <= 1'b1;
      blk_last  <= S_blk_tlast;
    end else if (text_done) begin
      blk_valid <= 1'b0;
      blk_last  <= 1'b0;
    end
  end

endmodule

// File: doc/aes_cbc_stream_source.md
AES_CBC_STREAM_SOURCE -- requirements
Module: aes_cbc_stream_source

Interface
REQ-001 SHALL have parameter M_AXIS_WIDTH, default 64, giving the output beat width in bits; legal values are 32, 64 and 128.
REQ-002 SHALL have port Clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port Rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port Cmd_valid, input, 1 bit: a message command is offered.
REQ-005 SHALL have port Cmd_ready, output, 1 bit: a command can be accepted.
REQ-006 SHALL have port Cmd_key, input, 256 bits: AES-256 key.
REQ-007 SHALL have port Cmd_iv, input, 128 bits: CBC IV.
REQ-008 SHALL have port Cmd_encrypt, input, 1 bit: 1 = encrypt, 0 = decrypt.
REQ-009 SHALL have port S_blk_tvalid, input, 1 bit: a payload block is offered.
REQ-010 SHALL have port S_blk_tready, output, 1 bit: a payload block can be accepted.
REQ-011 SHALL have port S_blk_tdata, input, 128 bits: payload block.
REQ-012 SHALL have port S_blk_tlast, input, 1 bit: this is the final block of the message.
REQ-013 SHALL have AXI-Stream master ports M_axis_tvalid (output, 1), M_axis_tready (input, 1), M_axis_tdata (output, M_AXIS_WIDTH), M_axis_tkeep (output, M_AXIS_WIDTH/8), M_axis_tlast (output, 1) and M_axis_tuser (output, 1): the feed to the AES-256 CBC core slave port.
REQ-014 SHALL have port Busy, output, 1 bit: a message is in progress.
REQ-015 SHALL have port Block_cnt, output, 16 bits: number of blocks fully sent in the current message.

Function
REQ-016 SHALL implement a one-hot FSM with states ST_IDLE, ST_KEY, ST_IV and ST_TEXT.
REQ-017 In ST_IDLE: Cmd_ready=1 and all M_axis outputs are 0.
- On Cmd_valid=1, capture key, IV and encrypt.
- Clear the word counter and Block_cnt.
- Go to ST_KEY.
REQ-018 In ST_KEY, drive M_axis_tvalid=1 and M_axis_tdata=key_reg[cnt*W +: W] (W=M_AXIS_WIDTH; word 0 is the least-significant word).
- After the handshake on word 256/W-1: go to ST_IV with cnt=0.
REQ-019 In ST_IV, drive iv_reg[cnt*W +: W] in the same way.
- After the handshake on word 128/W-1: go to ST_TEXT with cnt=0.
REQ-020 In ST_TEXT, drive M_axis_tvalid = blk_valid and M_axis_tdata = blk_reg[cnt*W +: W].
- Each handshake on word 128/W-1 increments Block_cnt (wraps at 16 bits) and clears cnt.
- If blk_last is set on that handshake: go to ST_IDLE.
REQ-021 A "handshake" is M_axis_tvalid & M_axis_tready in the same cycle.
- While tvalid=1 and tready=0, tdata, tlast and tuser SHALL be held stable.
- tvalid SHALL NOT drop before the handshake, except on reset.
REQ-022 M_axis_tuser SHALL equal the captured encrypt bit on every beat of the message.
REQ-023 M_axis_tkeep SHALL be all ones on every beat.
REQ-024 M_axis_tlast SHALL be 1 only on the last word of a block whose blk_last=1; it SHALL be 0 on all key and IV words.
REQ-025 The one-entry block buffer (blk_reg, blk_last, blk_valid) SHALL accept payload in ST_KEY, ST_IV and ST_TEXT.
- S_blk_tready = (state != ST_IDLE) & !(blk_valid & blk_last) & (!blk_valid | last-word handshake).
REQ-026 A simultaneous last-word handshake and S_blk acceptance SHALL replace the buffer with the new block, giving zero bubble.
REQ-027 The block arriving with tlast=1 SHALL close input acceptance until ST_IDLE is re-entered.
REQ-028 Cmd_ready=0 and S_blk_tready=0 in every state they are not asserted above; offered commands and blocks are then ignored.
REQ-029 Timing and throughput:
- A command accepted at edge N gives first key beat tvalid=1 in cycle N+1.
- Throughput is one beat per cycle under continuous tready.
- There SHALL be no idle cycle at the KEY->IV or IV->TEXT boundaries if a block is already buffered.
REQ-030 Busy = (state != ST_IDLE).
REQ-031 Block_cnt SHALL hold its value in ST_IDLE until the next command is accepted.

Reset
REQ-032 While Rst_n=0, with immediate (asynchronous) effect:
- state=ST_IDLE; cnt, Block_cnt, blk_valid, blk_last, key/IV/encrypt/block registers all 0.
- M_axis_tvalid, tlast, tuser, tdata and tkeep all 0; Busy=0.
REQ-033 While Rst_n=0, Cmd_ready=0 and S_blk_tready=0.
REQ-034 Reset asserted mid-message SHALL abort the message with no further beats; the next command restarts from key word 0.

Verification (W=64)
REQ-035 Reset: Rst_n=0 -> all outputs 0; release -> Cmd_ready=1, Busy=0.
REQ-036 Single block, tready=1:
- Stimulus: key=000102..1f, iv=0, block=00112233445566778899aabbccddeeff, encrypt=1.
- Response: 8 consecutive beats; beat 1 = key[63:0]; beat 7 = block[63:0]; tuser=1 on all beats; tlast=1 on beat 8 only.
- Afterwards Block_cnt=1 and Busy=0.
REQ-037 Three blocks presented back-to-back, tready=1 -> 12 beats with no gaps; tlast only on beat 12; Block_cnt=3.
REQ-038 Random tready stalls with encrypt=0:
- Word sequence identical to the unstalled run.
- tdata stable during stalls; no dropped or duplicated words; tuser=0 throughout.
REQ-039 Rst_n pulsed low during IV word 1 -> tvalid=0 immediately; a new command emits key word 0 first.
REQ-040 Cmd_valid while Busy, and S_blk_tvalid while in ST_IDLE -> both ignored (ready=0); the message in progress is unchanged.
